nv_ram_rwsp_fifo_ctrl: RTL and testbench
========================================

Name: nv_ram_rwsp_fifo_ctrl

Overview:
- Valid/ready FIFO controller that owns both ports of an external 80x14 two-port RAM with a registered read address (re) and a registered output (ore).
- Generates write address/enable on push, and schedules the 2-stage read pipeline (re then ore) on pop.
- Presents a registered valid/ready output with full backpressure.
- Sits between NVDLA datapath stages wherever an rwsp RAM buffers packets.

Parameters:
- DEPTH, 80, number of RAM entries; need not be a power of two.
- WIDTH, 14, payload width in bits.
- AW, 7, RAM address width; must satisfy 2^AW >= DEPTH.
- CW, 7, count width; must hold DEPTH+1.

Ports:
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  reset; asynchronous, active-low
- wr_pvld  in  1  push valid
- wr_prdy  out  1  push ready; high when RAM occupancy < DEPTH
- wr_pd  in  WIDTH  push payload
- rd_pvld  out  1  pop valid; output register holds data
- rd_prdy  in  1  pop ready
- rd_pd  out  WIDTH  pop payload; driven directly from ram_dout
- ram_wa  out  AW  RAM write address
- ram_we  out  1  RAM write enable
- ram_di  out  WIDTH  RAM write data; equals wr_pd
- ram_ra  out  AW  RAM read address
- ram_re  out  1  RAM read-address capture enable
- ram_ore  out  1  RAM output-register enable
- ram_dout  in  WIDTH  RAM registered output
- fifo_count  out  CW  RAM occupancy plus rd_pvld
- fifo_idle  out  1  high when fifo_count == 0 and no read is in flight

Behaviour:
- Reset values: wr_ptr=0, rd_ptr=0, ram_cnt=0, s1_vld=0, s2_vld=0. Consequently rd_pvld=0, wr_prdy=1, fifo_count=0, fifo_idle=1, and ram_we/ram_re/ram_ore=0.
- The address outputs are don't-care during reset. Reset mid-operation discards all contents; the RAM array itself is not cleared.

Push:
- push = wr_pvld & wr_prdy.
- On push: ram_we=1 and ram_wa=wr_ptr, both combinational from push.
- wr_ptr advances; wrap DEPTH-1 -> 0.

Read pipeline:
- s1 = address latched in RAM.
- s2 = data in RAM output register, equal to rd_pvld.
- s2_adv = ~s2_vld | rd_prdy.
- ram_ore = s1_vld & s2_adv. On ore: s2_vld<=1, s1_vld<=0 unless a new re fires in the same cycle, and ram_cnt decrements. The slot is freed only at ore, because the data has not been sampled before then.
- s1_free = ~s1_vld | ram_ore.
- ram_re = s1_free & (ram_cnt - s1_vld > 0), counting only entries not already in s1.
- ram_ra = rd_ptr. On re: s1_vld<=1 and rd_ptr advances, wrapping DEPTH-1 -> 0.
- Pop: on rd_pvld & rd_prdy with no ore, s2_vld<=0.
- ram_re must never fire while s1 holds and will not advance; it would overwrite the latched address.

Occupancy and counts:
- ram_cnt counts written entries not yet captured by ore.
- Net update: +push, -ore; simultaneous push and ore leave ram_cnt unchanged.
- wr_prdy = ram_cnt < DEPTH. Total capacity is DEPTH+1 (DEPTH in RAM plus the output register).
- fifo_count = ram_cnt + s2_vld.

Latency:
- Push in cycle N -> ram_re earliest N+1 -> ram_ore N+2 -> rd_pvld N+3 with rd_pd = ram_dout.
- Streaming with rd_prdy=1 sustains one pop per cycle.

Hazards:
- A write never targets an address in s1, because full is counted until ore.
- A write at N to the address read at N+1 is safe: M updates at the N edge.

Full/empty:
- Full: wr_prdy=0, push is ignored, and wr_pd is not written.
- Empty: ram_re=0; rd_pvld stays high if s2 still holds data.

Decomposition:
- Shared package holds DEPTH/WIDTH/AW/CW defaults and a pointer-increment-with-wrap function (ptr==DEPTH-1 ? 0 : ptr+1).
- No sub-module is needed. An optional sub-module nv_ram_rwsp_fifo_rdpipe implements the s1/s2 valid tracking and the re/ore generation. The RAM is instantiated by the parent, not inside this block.

Test Plan:
- Single push 0x1ABC at cycle 0 with rd_prdy=1 -> ram_we at 0, ram_re at 1, ram_ore at 2; rd_pvld=1 with rd_pd=0x1ABC at 3; fifo_count returns to 0 and fifo_idle=1 at 4.
- Push 81 values 0..80 with rd_prdy=0 -> wr_prdy drops after 81 accepted (80 in RAM + 1 in output reg); fifo_count=81; 82nd push held off.
- Release rd_prdy=1 after the fill -> data pops 0..80 in order, one per cycle.
- Wrap check: push/pop 200 sequential values with random rd_prdy (50%) -> in-order output; ram_wa and ram_ra go 79->0; no address >= 80 is ever issued.
- Backpressure in flight: hold rd_prdy=0 with s1 and s2 full and data pending -> ram_re=0, ram_ore=0, and ram_ra latch is not disturbed. Release -> no duplicate or lost words.
- Async reset asserted mid-stream with count=37 -> rd_pvld and ram_we/re/ore go 0 immediately; after release, fifo_count=0 and the first new push 0x0005 reads back 0x0005.

Source files
------------

// File: rtl/nv_ram_rwsp_fifo_ctrl_pkg.sv
// nv_ram_rwsp_fifo_ctrl_pkg: shared defaults and pointer helper for the rwsp RAM FIFO controller
//   DEPTH/WIDTH/AW/CW : default RAM geometry (80x14, 7-bit address, 7-bit count)
//   ptr_inc           : advance a RAM pointer, wrapping DEPTH-1 -> 0 (DEPTH need not be a power of two)
package nv_ram_rwsp_fifo_ctrl_pkg;
    localparam int DEPTH = 80;
    localparam int WIDTH = 14;
    localparam int AW    = 7;
    localparam int CW    = 7;

    function automatic int ptr_inc(input int p, input int depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction
endpackage

// File: rtl/nv_ram_rwsp_fifo_ctrl.sv
// nv_ram_rwsp_fifo_ctrl: valid/ready FIFO controller driving an external two-port RAM with registered read address and output
//   nvdla_core_clk/nvdla_core_rstn : clock, async active-low reset
//   wr_pvld/wr_prdy/wr_pd          : push handshake and payload
//   rd_pvld/rd_prdy/rd_pd          : pop handshake; payload comes straight from the RAM output register
//   ram_wa/ram_we/ram_di           : RAM write port
//   ram_ra/ram_re/ram_ore          : RAM read port (address capture, output register enable)
//   ram_dout                       : RAM registered output
//   fifo_count/fifo_idle           : occupancy (RAM + output register) and idle flag
module nv_ram_rwsp_fifo_ctrl
    import nv_ram_rwsp_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH_P = DEPTH,
    parameter int WIDTH_P = WIDTH,
    parameter int AW_P    = AW,
    parameter int CW_P    = CW
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rstn,
    input  logic               wr_pvld,
    output logic               wr_prdy,
    input  logic [WIDTH_P-1:0] wr_pd,
    output logic               rd_pvld,
    input  logic               rd_prdy,
    output logic [WIDTH_P-1:0] rd_pd,
    output logic [AW_P-1:0]    ram_wa,
    output logic               ram_we,
    output logic [WIDTH_P-1:0] ram_di,
    output logic [AW_P-1:0]    ram_ra,
    output logic               ram_re,
    output logic               ram_ore,
    input  logic [WIDTH_P-1:0] ram_dout,
    output logic [CW_P-1:0]    fifo_count,
    output logic               fifo_idle
);
    logic [AW_P-1:0] wr_ptr, rd_ptr;
    logic [CW_P-1:0] ram_cnt;
    logic            s1_vld, s2_vld;
    logic            push, s2_adv, s1_free;

    assign wr_prdy    = ram_cnt < CW_P'(DEPTH_P);
    assign push       = wr_pvld & wr_prdy;
    assign ram_we     = push;
    assign ram_wa     = wr_ptr;
    assign ram_di     = wr_pd;
    assign s2_adv     = ~s2_vld | rd_prdy;
    assign ram_ore    = s1_vld & s2_adv;
    assign s1_free    = ~s1_vld | ram_ore;
    // ram_cnt still includes the entry sitting in s1, so only issue a read if something beyond it exists
    assign ram_re     = s1_free & (ram_cnt > CW_P'(s1_vld));
    assign ram_ra     = rd_ptr;
    assign rd_pvld    = s2_vld;
    assign rd_pd      = ram_dout;
    assign fifo_count = ram_cnt + CW_P'(s2_vld);
    assign fifo_idle  = (fifo_count == '0) & ~s1_vld;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
        end else begin
            if (push) wr_ptr <= AW_P'(ptr_inc(int'(wr_ptr), DEPTH_P));
            if (ram_re) rd_ptr <= AW_P'(ptr_inc(int'(rd_ptr), DEPTH_P));
            s1_vld  <= ram_re | (s1_vld & ~ram_ore);
            s2_vld  <= ram_ore | (s2_vld & ~rd_prdy);
            // slot is released only when ore samples it, keeping writes off the latched read address
            ram_cnt <= ram_cnt + CW_P'(push) - CW_P'(ram_ore);
        end
    end
endmodule

// File: tb/tb_nv_ram_rwsp_fifo_ctrl.sv
// tb_nv_ram_rwsp_fifo_ctrl: randomized and directed checks of the rwsp FIFO controller against a queue model
module tb_nv_ram_rwsp_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_pvld = 1'b0, rd_prdy = 1'b0;
    logic [13:0] wr_pd = '0;
    logic        wr_prdy, rd_pvld, ram_we, ram_re, ram_ore, fifo_idle;
    logic [13:0] rd_pd, ram_di, ram_dout;
    logic [6:0]  ram_wa, ram_ra, fifo_count;
    logic [13:0] mem [80];
    logic [6:0]  ra_q;
    logic [13:0] q [$];
    int total = 0, bad = 0;
    int n_wr = 0, n_rd = 0, pops = 0, accepts = 0;
    logic l_we, l_re, l_ore, l_pvld;
    logic [13:0] l_pd;

    always #5 clk = ~clk;

    nv_ram_rwsp_fifo_ctrl dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
        .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore), .ram_dout(ram_dout),
        .fifo_count(fifo_count), .fifo_idle(fifo_idle)
    );

    always @(posedge clk) begin
        if (ram_we && ram_wa < 80) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
        if (ram_ore && ra_q < 80) ram_dout <= mem[ra_q];
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic pv, input logic [13:0] pd, input logic rr);
        logic acc, pop;
        wr_pvld = pv; wr_pd = pd; rd_prdy = rr;
        #1;
        l_we = ram_we; l_re = ram_re; l_ore = ram_ore; l_pvld = rd_pvld; l_pd = rd_pd;
        chk("count", int'(fifo_count), q.size());
        chk("idle", int'(fifo_idle), int'(q.size() == 0));
        if (q.size() < 80) chk("prdy_open", int'(wr_prdy), 1);
        if (q.size() > 80) chk("prdy_full", int'(wr_prdy), 0);
        acc = pv & wr_prdy;
        chk("we", int'(ram_we), int'(acc));
        if (ram_we) begin
            chk("wa", int'(ram_wa), n_wr % 80);
            chk("di", int'(ram_di), int'(pd));
        end
        if (ram_re) chk("ra", int'(ram_ra), n_rd % 80);
        pop = rd_pvld & rr;
        if (rd_pvld) chk("pvld_nonempty", int'(q.size() > 0), 1);
        if (pop && q.size() > 0) chk("rd_pd", int'(rd_pd), int'(q[0]));
        @(posedge clk);
        if (acc) begin q.push_back(pd); n_wr++; accepts++; end
        if (pop && q.size() > 0) begin void'(q.pop_front()); pops++; end
        if (l_re) n_rd++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() > 0; i++) step(1'b0, '0, 1'b1);
        chk("drained", q.size(), 0);
    endtask

    initial begin
        logic [6:0] ra_hold;
        int p0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_pvld", int'(rd_pvld), 0);
        chk("rst_prdy", int'(wr_prdy), 1);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_idle", int'(fifo_idle), 1);
        chk("rst_rdctl", int'({ram_re, ram_ore}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        step(1'b1, 14'h1ABC, 1'b1); chk("lat_we0", int'(l_we), 1);
        step(1'b0, '0, 1'b1);       chk("lat_re1", int'(l_re), 1);
        step(1'b0, '0, 1'b1);       chk("lat_ore2", int'(l_ore), 1);
        step(1'b0, '0, 1'b1);       chk("lat_pvld3", int'(l_pvld), 1); chk("lat_pd3", int'(l_pd), 'h1ABC);
        step(1'b0, '0, 1'b1);       chk("lat_idle4", int'(fifo_idle), 1);

        accepts = 0;
        for (int i = 0; i < 90 && accepts < 81; i++) step(1'b1, 14'(accepts), 1'b0);
        chk("fill_accepts", accepts, 81);
        chk("fill_count", int'(fifo_count), 81);
        step(1'b1, 14'h3FFF, 1'b0);
        chk("fill_held", accepts, 81);
        chk("fill_held_we", int'(l_we), 0);
        p0 = pops;
        for (int i = 0; i < 84; i++) step(1'b0, '0, 1'b1);
        chk("stream_pops", pops - p0, 81);
        chk("stream_empty", q.size(), 0);

        accepts = 0;
        for (int i = 0; i < 3000 && accepts < 200; i++)
            step(1'($urandom_range(0, 1)), 14'(accepts), 1'($urandom_range(0, 1)));
        chk("wrap_accepts", accepts, 200);
        drain(300);

        for (int i = 0; i < 6; i++) step(1'b1, 14'(100 + i), 1'b0);
        ra_hold = ram_ra;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0);
            chk("bp_re", int'(l_re), 0);
            chk("bp_ore", int'(l_ore), 0);
            chk("bp_ra", int'(ram_ra), int'(ra_hold));
        end
        p0 = pops;
        drain(20);
        chk("bp_pops", pops - p0, 6);

        for (int i = 0; i < 60 && q.size() < 37; i++) step(1'b1, 14'(i), 1'b0);
        chk("pre_rst_count", int'(fifo_count), 37);
        #3;
        rst_n = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b1;
        #1;
        chk("arst_pvld", int'(rd_pvld), 0);
        chk("arst_ctl", int'({ram_we, ram_re, ram_ore}), 0);
        q.delete(); n_wr = 0; n_rd = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_count", int'(fifo_count), 0);
        @(negedge clk);
        step(1'b1, 14'h0005, 1'b1);
        p0 = pops;
        drain(10);
        chk("post_rst_pop", pops - p0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end
endmodule
